// File: rtl/i2c_uart_responder_if.sv
// i2c_uart_responder_if: result-buffer pop and UART transmitter handshake bundle
interface i2c_uart_responder_if;
  logic        result_valid;
  logic [7:0]  result_addr;
  logic [2:0]  result_mode;
  logic [15:0] result_data;
  logic        result_error;
  logic        rd_result;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done_tick;
  logic        busy;
  logic        tx_timeout;
  modport master (
    output result_valid, result_addr, result_mode, result_data, result_error, tx_done_tick,
    input  rd_result, tx_start, tx_byte, busy, tx_timeout
  );
  modport slave (
    input  result_valid, result_addr, result_mode, result_data, result_error, tx_done_tick,
    output rd_result, tx_start, tx_byte, busy, tx_timeout
  );
endinterface

// File: rtl/i2c_uart_responder.sv
// i2c_uart_responder: pops I2C results and frames them as UART response packets
module i2c_uart_responder #(
  parameter int         TIMEOUT_CYCLES = 1000000000,
  parameter logic [7:0] START_BYTE     = 8'hFF,
  parameter logic [7:0] STOP_BYTE      = 8'hFF
) (
  input logic clk,
  input logic reset,
  i2c_uart_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, START, ADDR, STATUS, DATA_LO, DATA_HI, STOP} state_t;
  state_t state, state_n, adv;
  logic issued, issued_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] addr;
  logic [2:0] mode;
  logic [15:0] data;
  logic err;
  logic rd, start, timeout, has_data, two_bytes;
  assign has_data  = !err && (mode == 3'b100 || mode == 3'b101);
  assign two_bytes = !err && mode == 3'b101;
  // state, issue flag, watchdog counter and the result latched at pop time
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      issued <= 1'b0;
      cnt    <= '0;
      addr   <= '0;
      mode   <= '0;
      data   <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      issued <= issued_n;
      cnt    <= cnt_n;
      if (rd) begin
        addr <= bus.result_addr;
        mode <= bus.result_mode;
        data <= bus.result_data;
        err  <= bus.result_error;
      end
    end
  // byte that follows the current one; data bytes only for error-free reads
  always_comb begin
    adv = IDLE;
    case (state)
      START:   adv = ADDR;
      ADDR:    adv = STATUS;
      STATUS:  adv = has_data ? DATA_LO : STOP;
      DATA_LO: adv = two_bytes ? DATA_HI : STOP;
      DATA_HI: adv = STOP;
      default: adv = IDLE;
    endcase
  end
  // pop in idle, issue each byte once, advance on done, abandon on watchdog expiry
  always_comb begin
    state_n  = state;
    issued_n = issued;
    cnt_n    = cnt;
    rd       = 1'b0;
    start    = 1'b0;
    timeout  = 1'b0;
    if (state == IDLE) begin
      rd = bus.result_valid && !reset;
      if (rd) state_n = START;
    end else if (!issued) begin
      start    = 1'b1;
      issued_n = 1'b1;
      cnt_n    = '0;
    end else if (bus.tx_done_tick) begin
      issued_n = 1'b0;
      state_n  = adv;
    end else if (cnt == LAST) begin
      timeout  = 1'b1;
      issued_n = 1'b0;
      state_n  = IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  assign bus.tx_byte = state == START   ? START_BYTE :
                       state == ADDR    ? addr :
                       state == STATUS  ? {4'b0000, err, mode} :
                       state == DATA_LO ? data[7:0] :
                       state == DATA_HI ? data[15:8] :
                       state == STOP    ? STOP_BYTE : 8'h00;
  assign bus.rd_result  = rd;
  assign bus.tx_start   = start;
  assign bus.busy       = state != IDLE;
  assign bus.tx_timeout = timeout;
endmodule
